// File: rtl/video_timing_ctrl_if.sv
// Pixel-source and encoder-side signals of the video timing controller.
// master = timing controller, slave = the frame buffer / encoder side.
interface video_timing_ctrl_if;
  logic        i_en;
  logic [23:0] i_pix_rgb;
  logic        o_pix_req;
  logic [11:0] o_x;
  logic [11:0] o_y;
  logic        o_frame_start;
  logic        o_running;
  logic        o_blanking;
  logic [1:0]  o_ctrl_ch0;
  logic [1:0]  o_ctrl_ch1;
  logic [1:0]  o_ctrl_ch2;
  logic [7:0]  o_data_ch0;
  logic [7:0]  o_data_ch1;
  logic [7:0]  o_data_ch2;

  modport master (
    input  i_en, i_pix_rgb,
    output o_pix_req, o_x, o_y, o_frame_start, o_running, o_blanking,
           o_ctrl_ch0, o_ctrl_ch1, o_ctrl_ch2,
           o_data_ch0, o_data_ch1, o_data_ch2
  );

  modport slave (
    output i_en, i_pix_rgb,
    input  o_pix_req, o_x, o_y, o_frame_start, o_running, o_blanking,
           o_ctrl_ch0, o_ctrl_ch1, o_ctrl_ch2,
           o_data_ch0, o_data_ch1, o_data_ch2
  );
endinterface

// File: rtl/video_timing_ctrl.sv
// Frame scheduler: h/v timing, frame-buffer pixel requests and TMDS encoder inputs.
// Latency: request one cycle after the counter step, encoder side RD_LATENCY later; no backpressure.
module video_timing_ctrl #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter int RD_LATENCY = 1
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  video_timing_ctrl_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int LAT     = (RD_LATENCY < 1) ? 1 : ((RD_LATENCY > 4) ? 4 : RD_LATENCY);

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Encoder-side control word; sync fields carry the output level, not the "active" flag.
  typedef struct packed {
    logic blank;
    logic vsync;
    logic hsync;
  } enc_t;

  localparam enc_t ENC_IDLE = '{blank: 1'b1, vsync: ~VSYNC_POL, hsync: ~HSYNC_POL};

  state_t      state_q, state_d;
  logic [11:0] h_q, h_d;
  logic [11:0] v_q, v_d;
  logic        pix_req_q, pix_req_d;
  logic [11:0] x_q, x_d;
  logic [11:0] y_q, y_d;
  logic        frame_start_q, frame_start_d;
  logic        running_q, running_d;
  enc_t        enc_q, enc_d;
  enc_t        pipe_q [LAT];
  enc_t        pipe_d [LAT];

  logic        run_d;
  logic        active_d;
  logic        hs_act_d;
  logic        vs_act_d;
  enc_t        enc_out;

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    case (state_q)
      ST_IDLE: begin
        h_d = '0;
        v_d = '0;
        if (bus.i_en) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (h_q == H_LAST) begin
          h_d = '0;
          if (v_q == V_LAST) begin
            v_d = '0;
            // Stop only at the frame boundary so a frame is never cut short.
            if (!bus.i_en) begin
              state_d = ST_IDLE;
            end
          end else begin
            v_d = v_q + 12'd1;
          end
        end else begin
          h_d = h_q + 12'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        h_d     = '0;
        v_d     = '0;
      end
    endcase
  end

  // Request-stage outputs are computed from the next counter values so they leave flops.
  always_comb begin
    run_d    = (state_d == ST_RUN);
    active_d = run_d && (h_d < H_ACT) && (v_d < V_ACT);
    hs_act_d = run_d && (h_d >= HS_START) && (h_d < HS_END);
    vs_act_d = run_d && (v_d >= VS_START) && (v_d < VS_END);

    pix_req_d     = active_d;
    frame_start_d = run_d && (h_d == 12'd0) && (v_d == 12'd0);
    running_d     = run_d;

    x_d = x_q;
    y_d = y_q;
    if (!run_d) begin
      x_d = '0;
      y_d = '0;
    end else if (active_d) begin
      x_d = h_d;
      y_d = v_d;
    end

    enc_d.blank = ~active_d;
    enc_d.hsync = hs_act_d ? HSYNC_POL : ~HSYNC_POL;
    enc_d.vsync = vs_act_d ? VSYNC_POL : ~VSYNC_POL;
  end

  always_comb begin
    pipe_d[0] = enc_q;
    for (int i = 1; i < LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_IDLE;
      h_q           <= '0;
      v_q           <= '0;
      pix_req_q     <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
      running_q     <= 1'b0;
      enc_q         <= ENC_IDLE;
      for (int i = 0; i < LAT; i++) begin
        pipe_q[i] <= ENC_IDLE;
      end
    end else begin
      state_q       <= state_d;
      h_q           <= h_d;
      v_q           <= v_d;
      pix_req_q     <= pix_req_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_start_q <= frame_start_d;
      running_q     <= running_d;
      enc_q         <= enc_d;
      for (int i = 0; i < LAT; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign enc_out = pipe_q[LAT-1];

  assign bus.o_pix_req     = pix_req_q;
  assign bus.o_x           = x_q;
  assign bus.o_y           = y_q;
  assign bus.o_frame_start = frame_start_q;
  assign bus.o_running     = running_q;
  assign bus.o_blanking    = enc_out.blank;
  assign bus.o_ctrl_ch0    = {enc_out.vsync, enc_out.hsync};
  assign bus.o_ctrl_ch1    = 2'b00;
  assign bus.o_ctrl_ch2    = 2'b00;

  // Pixel data arrives exactly aligned with the delayed blanking flag, so gate it directly.
  assign bus.o_data_ch0 = enc_out.blank ? 8'h00 : bus.i_pix_rgb[7:0];
  assign bus.o_data_ch1 = enc_out.blank ? 8'h00 : bus.i_pix_rgb[15:8];
  assign bus.o_data_ch2 = enc_out.blank ? 8'h00 : bus.i_pix_rgb[23:16];

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Bench for video_timing_ctrl: three instances (latency 1/2/4, both sync polarities)
// against a linear-position frame model with a delayed-snapshot queue.
module tb_video_timing_ctrl;
  localparam int HA = 8, HFP = 2, HSW = 3, HBP = 1;
  localparam int VA = 4, VFP = 1, VSW = 1, VBP = 1;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FT = HT * VT;
  localparam int NDUT = 3;
  localparam int LAT [NDUT] = '{1, 2, 4};
  localparam bit POL [NDUT] = '{1'b0, 1'b0, 1'b1};

  typedef struct packed {
    logic        req;
    logic [11:0] x;
    logic [11:0] y;
    logic        fs;
    logic        run;
    logic        blank;
    logic [1:0]  c0;
    logic [1:0]  c1;
    logic [1:0]  c2;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic [7:0]  d2;
  } obs_t;

  typedef struct {
    bit          req;
    bit          hs;
    bit          vs;
    bit          fs;
    bit          run;
    int          lx;
    int          ly;
    logic [23:0] pix;
  } snap_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [23:0] src [NDUT];
  obs_t        obs [NDUT];

  int n_chk = 0;
  int n_err = 0;

  bit    m_run;
  int    m_pos;
  int    m_lx;
  int    m_ly;
  snap_t hist[$];

  always #5 clk = ~clk;

  video_timing_ctrl_if if_a ();
  video_timing_ctrl_if if_b ();
  video_timing_ctrl_if if_c ();

  video_timing_ctrl #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
                      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
                      .HSYNC_POL(POL[0]), .VSYNC_POL(POL[0]), .RD_LATENCY(LAT[0]))
    u_dut_a (.i_clk(clk), .i_rst_n(rst_n), .bus(if_a));

  video_timing_ctrl #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
                      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
                      .HSYNC_POL(POL[1]), .VSYNC_POL(POL[1]), .RD_LATENCY(LAT[1]))
    u_dut_b (.i_clk(clk), .i_rst_n(rst_n), .bus(if_b));

  video_timing_ctrl #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
                      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
                      .HSYNC_POL(POL[2]), .VSYNC_POL(POL[2]), .RD_LATENCY(LAT[2]))
    u_dut_c (.i_clk(clk), .i_rst_n(rst_n), .bus(if_c));

  assign if_a.i_en = en;
  assign if_b.i_en = en;
  assign if_c.i_en = en;
  assign if_a.i_pix_rgb = src[0];
  assign if_b.i_pix_rgb = src[1];
  assign if_c.i_pix_rgb = src[2];

  assign obs[0] = {if_a.o_pix_req, if_a.o_x, if_a.o_y, if_a.o_frame_start, if_a.o_running,
                   if_a.o_blanking, if_a.o_ctrl_ch0, if_a.o_ctrl_ch1, if_a.o_ctrl_ch2,
                   if_a.o_data_ch0, if_a.o_data_ch1, if_a.o_data_ch2};
  assign obs[1] = {if_b.o_pix_req, if_b.o_x, if_b.o_y, if_b.o_frame_start, if_b.o_running,
                   if_b.o_blanking, if_b.o_ctrl_ch0, if_b.o_ctrl_ch1, if_b.o_ctrl_ch2,
                   if_b.o_data_ch0, if_b.o_data_ch1, if_b.o_data_ch2};
  assign obs[2] = {if_c.o_pix_req, if_c.o_x, if_c.o_y, if_c.o_frame_start, if_c.o_running,
                   if_c.o_blanking, if_c.o_ctrl_ch0, if_c.o_ctrl_ch1, if_c.o_ctrl_ch2,
                   if_c.o_data_ch0, if_c.o_data_ch1, if_c.o_data_ch2};

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic snap_t idle_snap();
    snap_t s;
    s.req = 1'b0; s.hs = 1'b0; s.vs = 1'b0; s.fs = 1'b0; s.run = 1'b0;
    s.lx = 0; s.ly = 0; s.pix = 24'h0;
    return s;
  endfunction

  task automatic model_reset();
    m_run = 1'b0;
    m_pos = 0;
    m_lx  = 0;
    m_ly  = 0;
    hist.delete();
    for (int i = 0; i < 8; i++) hist.push_front(idle_snap());
  endtask

  // One pixel clock of the frame model: a single linear position walks the frame.
  task automatic model_step();
    snap_t s;
    int h, v;
    if (!m_run) begin
      if (en) begin m_run = 1'b1; m_pos = 0; end
    end else if (m_pos == FT - 1) begin
      m_pos = 0;
      if (!en) m_run = 1'b0;
    end else begin
      m_pos = m_pos + 1;
    end
    h = m_pos % HT;
    v = m_pos / HT;
    s.run = m_run;
    s.req = m_run && (h < HA) && (v < VA);
    s.hs  = m_run && (h >= HA + HFP) && (h < HA + HFP + HSW);
    s.vs  = m_run && (v >= VA + VFP) && (v < VA + VFP + VSW);
    s.fs  = m_run && (m_pos == 0);
    if (!m_run) begin
      m_lx = 0; m_ly = 0;
    end else if (s.req) begin
      m_lx = h; m_ly = v;
    end
    s.lx  = m_lx;
    s.ly  = m_ly;
    s.pix = {8'(v), 8'(h), 8'hA5};
    hist.push_front(s);
    if (hist.size() > 8) void'(hist.pop_back());
  endtask

  task automatic drive_sources();
    for (int d = 0; d < NDUT; d++) begin
      snap_t e;
      e = hist[LAT[d]];
      src[d] = e.req ? e.pix : 24'($urandom);
    end
  endtask

  task automatic check_all();
    snap_t r, e;
    logic [1:0] c0;
    logic [23:0] dat;
    r = hist[0];
    for (int d = 0; d < NDUT; d++) begin
      e   = hist[LAT[d]];
      c0  = {(e.vs ? POL[d] : !POL[d]), (e.hs ? POL[d] : !POL[d])};
      dat = e.req ? e.pix : 24'h0;
      chk_eq($sformatf("d%0d_pix_req", d), 32'(obs[d].req), 32'(r.req));
      chk_eq($sformatf("d%0d_x", d), 32'(obs[d].x), 32'(r.lx));
      chk_eq($sformatf("d%0d_y", d), 32'(obs[d].y), 32'(r.ly));
      chk_eq($sformatf("d%0d_frame_start", d), 32'(obs[d].fs), 32'(r.fs));
      chk_eq($sformatf("d%0d_running", d), 32'(obs[d].run), 32'(r.run));
      chk_eq($sformatf("d%0d_blanking", d), 32'(obs[d].blank), 32'(!e.req));
      chk_eq($sformatf("d%0d_ctrl0", d), 32'(obs[d].c0), 32'(c0));
      chk_eq($sformatf("d%0d_ctrl12", d), 32'({obs[d].c1, obs[d].c2}), 32'(0));
      chk_eq($sformatf("d%0d_data", d), 32'({obs[d].d2, obs[d].d1, obs[d].d0}), 32'(dat));
    end
  endtask

  // Called at a falling edge; ends at the next falling edge after checking.
  task automatic tick(input bit en_v, input bit rstn_v);
    en    = en_v;
    rst_n = rstn_v;
    if (!rstn_v) begin
      model_reset();
      drive_sources();
      #1;
      check_all();
    end
    @(posedge clk);
    #1;
    if (!rst_n) model_reset();
    else model_step();
    drive_sources();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int n_req, n_fs, fs_first, fs_second, n_hs_a, n_vs_a, n_hs_c, n_vs_c, n_blank, n_run;
    en    = 1'b0;
    rst_n = 1'b0;
    model_reset();
    drive_sources();
    repeat (2) @(negedge clk);

    // Reset, then idle with run request low.
    repeat (3) tick(1'b0, 1'b0);
    repeat (20) tick(1'b0, 1'b1);
    chk_eq("idle_ctrl0_a", 32'(obs[0].c0), 32'(2'b11));
    chk_eq("idle_ctrl0_c", 32'(obs[2].c0), 32'(2'b00));

    // Two full frames with aggregate timing counts.
    n_req = 0; n_fs = 0; fs_first = -1; fs_second = -1;
    n_hs_a = 0; n_vs_a = 0; n_hs_c = 0; n_vs_c = 0; n_blank = 0;
    for (int i = 0; i < 2 * FT; i++) begin
      tick(1'b1, 1'b1);
      if (obs[0].req) n_req++;
      if (!obs[0].blank) n_blank++;
      if (obs[0].fs) begin
        n_fs++;
        if (fs_first < 0) fs_first = i; else fs_second = i;
      end
      if (!obs[0].c0[0]) n_hs_a++;
      if (!obs[0].c0[1]) n_vs_a++;
      if (obs[2].c0[0]) n_hs_c++;
      if (obs[2].c0[1]) n_vs_c++;
    end
    chk_eq("frame_req_count", 32'(n_req), 32'(2 * HA * VA));
    chk_eq("frame_blank_low_count", 32'(n_blank), 32'(2 * HA * VA));
    chk_eq("frame_start_count", 32'(n_fs), 32'(2));
    chk_eq("frame_start_first", 32'(fs_first), 32'(0));
    chk_eq("frame_start_period", 32'(fs_second - fs_first), 32'(FT));
    chk_eq("hsync_low_cycles", 32'(n_hs_a), 32'(2 * VT * HSW));
    chk_eq("vsync_low_cycles", 32'(n_vs_a), 32'(2 * VSW * HT));
    chk_eq("hsync_high_cycles_pol1", 32'(n_hs_c), 32'(2 * VT * HSW - HSW));
    chk_eq("vsync_high_cycles_pol1", 32'(n_vs_c), 32'(2 * VSW * HT));

    // Drop the run request at v=2,h=3: the frame must finish, then stop.
    repeat (2 * HT + 3) tick(1'b1, 1'b1);
    n_req = 0; n_run = 0;
    for (int i = 0; i < FT - (2 * HT + 3) + 20; i++) begin
      tick(1'b0, 1'b1);
      if (obs[0].req) n_req++;
      if (obs[0].run) n_run++;
    end
    chk_eq("stop_tail_running", 32'(n_run), 32'(FT - (2 * HT + 3)));
    chk_eq("stop_tail_reqs", 32'(n_req), 32'((HA - 3) + HA));

    // Asynchronous reset mid-line at h=5, then restart from (0,0).
    repeat (6) tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    chk_eq("restart_req", 32'(obs[0].req), 32'(1));
    chk_eq("restart_xy", 32'({obs[0].x, obs[0].y}), 32'(0));
    repeat (20) tick(1'b1, 1'b1);

    // Random run-request changes and occasional reset pulses.
    begin
      bit e_r;
      e_r = 1'b1;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 149) == 0) e_r = ~e_r;
        if ($urandom_range(0, 499) == 0) begin
          repeat ($urandom_range(1, 3)) tick(e_r, 1'b0);
        end else begin
          tick(e_r, 1'b1);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
